// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the wait-state data-memory responder
package dmem_pkg;

    // Word width the request hold register is built for; the responder checks its
    // DATA_WIDTH parameter against this at elaboration.
    localparam int DMEM_DATA_WIDTH = 32;
    localparam int LANES           = DMEM_DATA_WIDTH / 8;

    // The wait counter is 4 bits wide, so this is the longest latency it can count.
    localparam int MAX_LATENCY     = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Request fields captured at acceptance; the bus may change freely afterwards.
    typedef struct packed {
        logic                       we;
        logic [31:0]                addr;
        logic [DMEM_DATA_WIDTH-1:0] wdata;
        logic [LANES-1:0]           be;
    } req_hold_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - byte-enabled word array, synchronous write, combinational read
//
// Ports:
//   clk    rising-edge clock for writes
//   we     write strobe for this edge
//   addr   word index, shared by the read and the write
//   wdata  write data
//   be     per-byte write enables
//   rdata  combinational read of word addr
//
// Contents are deliberately not reset.
module dmem_array #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int BYTE_LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_wait_responder.sv
// rtl/dmem_wait_responder.sv - data-memory bus responder with a fixed number of wait cycles
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   req_valid  request present
//   req_ready  responder accepts a request this cycle (IDLE only)
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_be     store byte enables
//   rsp_valid  response present, held until rsp_ready
//   rsp_ready  initiator takes the response
//   rsp_rdata  load data; 0 for stores and errors
//   rsp_err    misaligned or out-of-range access
//   busy       a transaction is in flight
module dmem_wait_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [31:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy
);

    generate
        if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
            $error("dmem_wait_responder: LATENCY must be within 1..15");
        end
        if (DATA_WIDTH != DMEM_DATA_WIDTH) begin : g_bad_width
            $error("dmem_wait_responder: DATA_WIDTH must match dmem_pkg::DMEM_DATA_WIDTH");
        end
    endgenerate

    dmem_state_t           state;
    logic [3:0]            wait_cnt;
    req_hold_t             hold;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  addr_err;
    logic                  commit;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Ready is gated by reset directly so it reads 0 for the whole time reset is low.
    assign req_ready    = reset && (state == IDLE);
    assign busy         = (state != IDLE);

    assign word_idx     = hold.addr[ADDR_WIDTH+1:2];
    assign misaligned   = |hold.addr[1:0];
    assign out_of_range = |hold.addr[31:ADDR_WIDTH+2];
    assign addr_err     = misaligned | out_of_range;

    // The edge that moves WAIT -> RESP is the commit point. Gating with reset means a
    // store caught by reset on that very edge is dropped along with the transaction.
    assign commit       = reset && (state == WAIT) && (wait_cnt == 4'd0);
    assign mem_we       = commit && hold.we && !addr_err;

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_idx),
        .wdata (hold.wdata),
        .be    (hold.be),
        .rdata (mem_rdata)
    );

    // Request capture; only meaningful once a transaction is accepted, so no reset.
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            hold.we    <= req_we;
            hold.addr  <= req_addr;
            hold.wdata <= req_wdata;
            hold.be    <= req_be;
        end
    end

    // Every accepted request goes through WAIT, including LATENCY==1 (counter starts
    // at 0), so rsp_valid always rises exactly LATENCY edges after acceptance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wait_cnt <= 4'(LATENCY - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= addr_err;
                        // Loads sample the array on the same edge a store would write.
                        rsp_rdata <= (addr_err || hold.we) ? '0 : mem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb/tb_dmem_wait_responder.sv - randomized self-checking bench for dmem_wait_responder
module tb_dmem_wait_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    int          n_chk  = 0;
    int          n_fail = 0;
    int          lat_exp [2] = '{2, 1};
    logic [31:0] mem_m [2][DEPTH];

    always #5 clk = ~clk;

    dmem_wait_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(2)) u_dut_lat2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    dmem_wait_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(1)) u_dut_lat1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    // Reference: word memory with byte lanes; errors for misaligned or beyond-depth addresses.
    task automatic model(input int d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] er, output logic ee);
        int idx;
        if ((addr % 4) != 0 || addr >= 4 * DEPTH) begin
            er = 32'h0;
            ee = 1'b1;
            return;
        end
        idx = int'(addr / 4);
        ee  = 1'b0;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_m[d][idx][8*b +: 8] = wdata[8*b +: 8];
            er = 32'h0;
        end else begin
            er = mem_m[d][idx];
        end
    endtask

    // Drives one transaction starting at a negedge; returns what was observed.
    // Request lines carry junk with req_valid high while the transaction is in flight.
    task automatic xact(input int d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int stall, input bit early,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output bit stable, output bit ready_ok);
        int guard;
        stable = 1'b1; ready_ok = 1'b1; lat = -1; rdata = 32'h0; err = 1'b0;
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_wdata[d] = wdata; req_be[d] = be; rsp_ready[d] = early;
        guard = 0;
        while (req_ready[d] !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_we[d] = 1'($urandom); req_addr[d] = $urandom;
        req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (rsp_valid[d] === 1'b1) begin
                lat = k;
                break;
            end
            if (req_ready[d] !== 1'b0) ready_ok = 1'b0;
        end
        if (lat < 0) begin
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b0;
            return;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        if (req_ready[d] !== 1'b0) ready_ok = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rdata || rsp_err[d] !== err) stable = 1'b0;
            if (req_ready[d] !== 1'b0) ready_ok = 1'b0;
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b0;
        if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0) ready_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if ({req_ready[d], rsp_valid[d], busy[d]} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL reset_hold d%0d ready/valid/busy got %b%b%b exp 000",
                             d, req_ready[d], rsp_valid[d], busy[d]);
                end
            end
        end
        reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (req_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release d%0d ready/busy got %b%b exp 10", d, req_ready[d], busy[d]);
            end
        end
    endtask

    // Gives every word a defined value so later loads have something to compare against.
    task automatic test_fill();
        logic [31:0] r, er, wd;
        logic e, ee;
        int lat;
        bit st, rk;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wd = $urandom;
                model(d, 1'b1, 32'(4 * i), wd, 4'hF, er, ee);
                xact(d, 1'b1, 32'(4 * i), wd, 4'hF, 0, 1'b0, r, e, lat, st, rk);
                n_chk++;
                if (r !== er || e !== ee || lat !== lat_exp[d] || !rk) begin
                    n_fail++;
                    $display("FAIL fill d%0d word %0d rdata/err/lat/ready got %h/%b/%0d/%b exp %h/%b/%0d/1",
                             d, i, r, e, lat, rk, er, ee, lat_exp[d]);
                end
            end
        end
    endtask

    task automatic test_directed();
        bit          t_we   [10] = '{1, 0, 1, 0, 1, 0, 0, 1, 1, 0};
        logic [31:0] t_addr [10] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h10,
                                     32'h10, 32'h12, 32'h00, 32'h100, 32'h00};
        logic [31:0] t_wd   [10] = '{32'hDEADBEEF, 32'h0, 32'h000000AA, 32'h0, 32'hFFFFFFFF,
                                     32'h0, 32'h0, 32'h12345678, 32'hCAFEF00D, 32'h0};
        logic [3:0]  t_be   [10] = '{4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0};
        logic [31:0] t_rd   [10] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEAA, 32'h0,
                                     32'hDEADBEAA, 32'h0, 32'h0, 32'h0, 32'h12345678};
        logic        t_err  [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        logic [31:0] r, er;
        logic e, ee;
        int lat;
        bit st, rk;
        for (int i = 0; i < 10; i++) begin
            model(0, t_we[i], t_addr[i], t_wd[i], t_be[i], er, ee);
            xact(0, t_we[i], t_addr[i], t_wd[i], t_be[i], 0, 1'b0, r, e, lat, st, rk);
            n_chk++;
            if (r !== t_rd[i] || e !== t_err[i]) begin
                n_fail++;
                $display("FAIL directed step %0d rdata/err got %h/%b exp %h/%b", i, r, e, t_rd[i], t_err[i]);
            end
            n_chk++;
            if (lat !== 2 || !rk) begin
                n_fail++;
                $display("FAIL directed_timing step %0d lat/ready got %0d/%b exp 2/1", i, lat, rk);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r, er;
        logic e, ee;
        int lat;
        bit st, rk;
        for (int d = 0; d < 2; d++) begin
            model(d, 1'b1, 32'h30, 32'h5A5A1234, 4'hF, er, ee);
            xact(d, 1'b1, 32'h30, 32'h5A5A1234, 4'hF, 0, 1'b0, r, e, lat, st, rk);
            model(d, 1'b0, 32'h30, 32'h0, 4'h0, er, ee);
            xact(d, 1'b0, 32'h30, 32'h0, 4'h0, 5, 1'b0, r, e, lat, st, rk);
            n_chk++;
            if (r !== 32'h5A5A1234 || e !== 1'b0 || lat !== lat_exp[d]) begin
                n_fail++;
                $display("FAIL stall_data d%0d rdata/err/lat got %h/%b/%0d exp 5a5a1234/0/%0d",
                         d, r, e, lat, lat_exp[d]);
            end
            n_chk++;
            if (!st || !rk) begin
                n_fail++;
                $display("FAIL stall_hold d%0d stable/ready_ok got %b/%b exp 1/1", d, st, rk);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] r, er, a, wd;
        logic [3:0] be;
        logic e, ee;
        bit we, early, st, rk;
        int lat, sel, stall, d;
        for (int n = 0; n < 240; n++) begin
            d   = (n % 4 == 3) ? 1 : 0;
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel == 8) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else               a = ($urandom | 32'h100) & ~32'h3;
            we    = 1'($urandom);
            wd    = $urandom;
            be    = 4'($urandom);
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            early = (stall == 0) && 1'($urandom);
            model(d, we, a, wd, be, er, ee);
            xact(d, we, a, wd, be, stall, early, r, e, lat, st, rk);
            n_chk++;
            if (r !== er || e !== ee) begin
                n_fail++;
                $display("FAIL rand %0d d%0d we=%b addr=%h be=%h rdata/err got %h/%b exp %h/%b",
                         n, d, we, a, be, r, e, er, ee);
            end
            n_chk++;
            if (lat !== lat_exp[d] || !st || !rk) begin
                n_fail++;
                $display("FAIL rand_timing %0d d%0d lat/stable/ready got %0d/%b/%b exp %0d/1/1",
                         n, d, lat, st, rk, lat_exp[d]);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r, er;
        logic e, ee;
        int lat;
        bit st, rk;
        for (int d = 0; d < 2; d++) begin
            model(d, 1'b1, 32'h20, 32'h0BADCAFE, 4'hF, er, ee);
            xact(d, 1'b1, 32'h20, 32'h0BADCAFE, 4'hF, 0, 1'b0, r, e, lat, st, rk);
            req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = 32'h20;
            req_wdata[d] = 32'h11223344; req_be[d] = 4'hF;
            @(posedge clk);
            #1 req_valid[d] = 1'b0;
            @(negedge clk);
            n_chk++;
            if (busy[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_busy d%0d busy got %b exp 1", d, busy[d]);
            end
            reset = 1'b0;
            repeat (2) @(negedge clk);
            n_chk++;
            if ({req_ready[d], rsp_valid[d], busy[d]} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_reset d%0d ready/valid/busy got %b%b%b exp 000",
                         d, req_ready[d], rsp_valid[d], busy[d]);
            end
            reset = 1'b1;
            @(negedge clk);
            model(d, 1'b0, 32'h20, 32'h0, 4'h0, er, ee);
            xact(d, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, r, e, lat, st, rk);
            n_chk++;
            if (r !== 32'h0BADCAFE || e !== 1'b0 || lat !== lat_exp[d]) begin
                n_fail++;
                $display("FAIL abort_nowrite d%0d rdata/err/lat got %h/%b/%0d exp 0badcafe/0/%0d",
                         d, r, e, lat, lat_exp[d]);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
            req_wdata[d] = 32'h0; req_be[d] = 4'h0; rsp_ready[d] = 1'b0;
        end
        test_reset();
        test_fill();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
